// File: rtl/operand_entry_fsm.sv
// Keypad-side operand collector for the hex adder: gathers hex digits into operands and
// drives the arithmetic FSM's new_input / finish_input / accumulate_enable handshake.
module operand_entry_fsm #(
  parameter int unsigned NUM_DIGITS = 3,
  localparam int unsigned W  = 4 * NUM_DIGITS,
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_valid,
  input  logic          key_is_cmd,
  input  logic [3:0]    key_code,
  output logic [W-1:0]  num1_hex,
  output logic [W-1:0]  num2_hex,
  output logic          new_input,
  output logic          finish_input,
  output logic          accumulate_enable,
  output logic [W-1:0]  entry_hex,
  output logic [CW-1:0] entry_cnt,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    StEnterA   = 2'd0,
    StEnterB   = 2'd1,
    StResult   = 2'd2,
    StEnterAcc = 2'd3
  } state_e;

  localparam logic [3:0] CmdAdd = 4'h0;
  localparam logic [3:0] CmdEq  = 4'h1;
  localparam logic [3:0] CmdClr = 4'h2;
  localparam logic [3:0] CmdFin = 4'h3;

  state_e        state_q, state_d;
  logic [W-1:0]  num1_q, num1_d;
  logic [W-1:0]  num2_q, num2_d;
  logic [W-1:0]  entry_q, entry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          new_q, new_d;
  logic          fin_q, fin_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEnterA;
      num1_q  <= '0;
      num2_q  <= '0;
      entry_q <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      new_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      new_q   <= new_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    new_d   = 1'b0;
    fin_d   = 1'b0;

    if (key_valid) begin
      if (!key_is_cmd) begin
        // Digits beyond the operand width are dropped rather than scrolling old ones out.
        if (state_q != StResult && cnt_q < CW'(NUM_DIGITS)) begin
          entry_d = (entry_q << 4) | W'(key_code);
          cnt_d   = cnt_q + CW'(1);
        end
      end else begin
        case (key_code)
          CmdAdd: begin
            if (state_q == StEnterA) begin
              num1_d  = entry_q;
              entry_d = '0;
              cnt_d   = '0;
              state_d = StEnterB;
            end else if (state_q == StResult) begin
              entry_d = '0;
              cnt_d   = '0;
              acc_d   = 1'b1;
              state_d = StEnterAcc;
            end
          end
          CmdEq: begin
            if (state_q == StEnterB || state_q == StEnterAcc) begin
              num2_d  = entry_q;
              new_d   = 1'b1;
              state_d = StResult;
            end
          end
          CmdClr: begin
            if (state_q != StResult) begin
              entry_d = '0;
              cnt_d   = '0;
            end
          end
          CmdFin: begin
            num1_d  = '0;
            num2_d  = '0;
            entry_d = '0;
            cnt_d   = '0;
            acc_d   = 1'b0;
            fin_d   = 1'b1;
            state_d = StEnterA;
          end
          default: ;
        endcase
      end
    end
  end

  assign num1_hex          = num1_q;
  assign num2_hex          = num2_q;
  assign new_input         = new_q;
  assign finish_input      = fin_q;
  assign accumulate_enable = acc_q;
  assign entry_hex         = entry_q;
  assign entry_cnt         = cnt_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Directed bench for operand_entry_fsm: a digit-queue model checked every cycle, plus
// literal expectations at the key points of each scenario.
module tb_operand_entry_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic        key_is_cmd = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [11:0] num1_hex, num2_hex, entry_hex;
  logic        new_input, finish_input, accumulate_enable;
  logic [1:0]  entry_cnt, state_o;

  operand_entry_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .key_valid         (key_valid),
    .key_is_cmd        (key_is_cmd),
    .key_code          (key_code),
    .num1_hex          (num1_hex),
    .num2_hex          (num2_hex),
    .new_input         (new_input),
    .finish_input      (finish_input),
    .accumulate_enable (accumulate_enable),
    .entry_hex         (entry_hex),
    .entry_cnt         (entry_cnt),
    .state_o           (state_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode name, committed operands, and the typed digits as a queue.
  int unsigned m_state = 0;  // 0 A, 1 B, 2 RESULT, 3 ACC
  int          m_num1 = 0, m_num2 = 0;
  int          digs[$];
  bit          m_acc = 0, m_new = 0, m_fin = 0;
  bit          started = 0;

  function automatic int entry_val();
    int v = 0;
    foreach (digs[i]) v = v * 16 + digs[i];
    return v;
  endfunction

  always @(posedge clk) begin
    started = 1;
    m_new   = 0;
    m_fin   = 0;
    if (rst) begin
      m_state = 0; m_num1 = 0; m_num2 = 0; m_acc = 0;
      digs.delete();
    end else if (key_valid) begin
      if (!key_is_cmd) begin
        if (m_state != 2 && digs.size() < 3) digs.push_back(int'(key_code));
      end else if (key_code == 4'h0) begin
        if (m_state == 0) begin
          m_num1 = entry_val(); digs.delete(); m_state = 1;
        end else if (m_state == 2) begin
          digs.delete(); m_acc = 1; m_state = 3;
        end
      end else if (key_code == 4'h1) begin
        if (m_state == 1 || m_state == 3) begin
          m_num2 = entry_val(); m_new = 1; m_state = 2;
        end
      end else if (key_code == 4'h2) begin
        if (m_state != 2) digs.delete();
      end else if (key_code == 4'h3) begin
        m_num1 = 0; m_num2 = 0; m_acc = 0; m_fin = 1; m_state = 0;
        digs.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("num1_hex", int'(num1_hex), m_num1);
      check("num2_hex", int'(num2_hex), m_num2);
      check("entry_hex", int'(entry_hex), entry_val());
      check("entry_cnt", int'(entry_cnt), digs.size());
      check("state_o", int'(state_o), int'(m_state));
      check("accumulate_enable", int'(accumulate_enable), int'(m_acc));
      check("new_input", int'(new_input), int'(m_new));
      check("finish_input", int'(finish_input), int'(m_fin));
    end
  end

  // Two idle cycles, one-cycle strobe; returns just after the edge where the key took effect.
  task automatic press(input bit cmd, input logic [3:0] code);
    repeat (2) @(posedge clk);
    #2 key_valid = 1'b1; key_is_cmd = cmd; key_code = code;
    @(posedge clk);
    #2 key_valid = 1'b0;
  endtask

  task automatic dig(input logic [3:0] d);
    press(1'b0, d);
  endtask

  task automatic cmd(input logic [3:0] c);
    press(1'b1, c);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check("reset state", int'(state_o), 0);
    check("reset num1", int'(num1_hex), 0);
    check("reset entry_cnt", int'(entry_cnt), 0);

    // Basic add
    dig(4'h1); dig(4'h2); dig(4'h3);
    check("entry 123", int'(entry_hex), 'h123);
    cmd(4'h0);
    check("num1 123", int'(num1_hex), 'h123);
    check("state B", int'(state_o), 1);
    dig(4'h0); dig(4'hF); cmd(4'h1);
    check("t1 new_input", int'(new_input), 1);
    check("t1 num1", int'(num1_hex), 'h123);
    check("t1 num2", int'(num2_hex), 'h00F);
    check("t1 acc", int'(accumulate_enable), 0);
    check("t1 state", int'(state_o), 2);
    dig(4'h9);  // ignored in RESULT
    cmd(4'h7);  // unknown command
    check("result digit ignored", int'(state_o), 2);

    // Overflow digits
    cmd(4'h3);
    check("fin pulse", int'(finish_input), 1);
    dig(4'hA); dig(4'hB); dig(4'hC); dig(4'hD); dig(4'hE);
    check("overflow entry", int'(entry_hex), 'hABC);
    check("overflow cnt", int'(entry_cnt), 3);
    cmd(4'h0);
    check("num1 ABC", int'(num1_hex), 'hABC);
    cmd(4'h1);  // empty EQ commits 0
    check("empty eq num2", int'(num2_hex), 0);
    check("empty eq new", int'(new_input), 1);

    // Accumulation loops
    cmd(4'h0); dig(4'h5); cmd(4'h1);
    check("acc1 num2", int'(num2_hex), 'h005);
    check("acc1 new", int'(new_input), 1);
    check("acc1 acc", int'(accumulate_enable), 1);
    cmd(4'h0); dig(4'h1); dig(4'h0); cmd(4'h1);
    check("acc2 num2", int'(num2_hex), 'h010);
    check("acc2 new", int'(new_input), 1);
    check("acc2 acc", int'(accumulate_enable), 1);

    // CLR
    cmd(4'h3);
    dig(4'h7); dig(4'h7); cmd(4'h2);
    check("clr cnt", int'(entry_cnt), 0);
    dig(4'h4); cmd(4'h0); cmd(4'h1);
    check("clr num1", int'(num1_hex), 'h004);
    check("clr num2", int'(num2_hex), 0);
    check("clr new", int'(new_input), 1);

    // FIN in ENTER_B with pending digits
    cmd(4'h3);
    dig(4'h1); cmd(4'h0); dig(4'h2); dig(4'h3);
    cmd(4'h3);
    check("fin2 pulse", int'(finish_input), 1);
    check("fin2 new", int'(new_input), 0);
    check("fin2 num1", int'(num1_hex), 0);
    check("fin2 entry", int'(entry_hex), 0);
    check("fin2 state", int'(state_o), 0);
    @(posedge clk); #2;
    check("fin2 one cycle", int'(finish_input), 0);

    // Reset in ENTER_ACC with two digits pending
    dig(4'h6); cmd(4'h0); cmd(4'h1); cmd(4'h0); dig(4'h9); dig(4'h8);
    check("pre-rst state", int'(state_o), 3);
    check("pre-rst cnt", int'(entry_cnt), 2);
    check("pre-rst num1", int'(num1_hex), 'h006);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    check("rst state", int'(state_o), 0);
    check("rst cnt", int'(entry_cnt), 0);
    check("rst acc", int'(accumulate_enable), 0);
    check("rst num1", int'(num1_hex), 0);
    check("rst new", int'(new_input), 0);
    check("rst fin", int'(finish_input), 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
